fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
- Write-side pointer controller for the FIFO.
- Accepts write requests, gates them against the full flag, and advances a binary write counter.
- Drives the SIZE-bit Gray-coded w_pointer consumed by the full-flag stage, plus the memory write address and write enable.
- Also reports fill level, almost-full and a sticky overflow error.

Parameters:
- SIZE, 4: pointer width in bits, including the wrap bit. FIFO depth = 2^(SIZE-1). Minimum 3.
- AF_LEVEL, 6: almost_full asserts when word count >= AF_LEVEL. Legal range 1..2^(SIZE-1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_req  input  1  write request from the producer, sampled on the clk rising edge.
- f_flag  input  1  full flag from the full-flag stage; when 1, writes are refused.
- r_pointer  input  SIZE  Gray-coded read pointer from the read side.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- w_pointer  output  SIZE  registered Gray-coded write pointer.
- w_addr  output  SIZE-1  memory write address, equal to w_bin[SIZE-2:0].
- mem_we  output  1  memory write enable.
- w_count  output  SIZE  words currently stored, range 0..2^(SIZE-1).
- almost_full  output  1  registered; 1 when the stored level is >= AF_LEVEL.
- overflow  output  1  sticky; set when a write is attempted while full.

Behaviour:
- Reset (rst_n=0, asynchronous): w_bin=0, w_pointer=0, overflow=0, almost_full=0.
  - Consequently w_addr=0, and mem_we=0 is forced while rst_n=0.
  - Reset asserted mid-operation discards any in-flight write; no memory write occurs in that cycle.
- Accept condition: accept = wr_req & ~f_flag (combinational). mem_we = accept.
- On a clk edge with accept=1:
  - w_bin <= w_bin + 1, modulo 2^SIZE.
  - w_pointer <= (w_bin+1) ^ ((w_bin+1) >> 1). Gray is computed from the next binary value and registered, so w_pointer never glitches and changes exactly one bit per accepted write.
  - Memory writes data at w_addr, which reflects the pre-increment w_bin.
- With accept=0: w_bin and w_pointer hold.
- Wrap-around: w_bin rolls from 2^SIZE-1 to 0. The wrap bit w_bin[SIZE-1] toggles every 2^(SIZE-1) writes, and w_addr wraps from 2^(SIZE-1)-1 to 0.
- Fill level:
  - r_bin = Gray-to-binary of r_pointer, computed combinationally as a prefix XOR from the MSB.
  - w_count = (w_bin - r_bin) mod 2^SIZE, combinational from the w_bin register and the r_pointer input.
  - Empty: w_count=0. Full: w_count = 2^(SIZE-1).
- almost_full: registered, almost_full <= (w_count_next >= AF_LEVEL).
  - w_count_next uses post-accept w_bin and the current r_pointer.
  - Result: almost_full is valid the cycle after the write that reached the threshold.
- overflow:
  - Set on a clk edge with wr_req & f_flag.
  - Cleared on a clk edge with clr_ovf=1 only if no overflow event occurs in the same cycle; set has priority over clear.
  - A refused write never changes w_bin, w_pointer or memory.
- Simultaneous read and write: no interaction in this block. w_count reflects both the new w_bin and the new r_pointer in the cycle after their edges.
- Latency: mem_we is zero-cycle from wr_req. w_pointer updates one cycle after the accepted request.

Test Plan (SIZE=4, AF_LEVEL=6):
- Reset: drive rst_n=0 mid-stream with wr_req=1 -> w_pointer=0000, w_addr=000, mem_we=0, w_count=0, overflow=0, immediately (asynchronous).
- Gray walk: r_pointer=0000, f_flag=0, wr_req=1 for 8 cycles -> w_pointer=0001,0011,0010,0110,0111,0101,0100,1100; w_addr=0..7 during the writes; w_count reaches 8; the full stage then asserts on 1100 vs 0000.
- Full refusal: hold f_flag=1 with wr_req=1 for 3 cycles -> mem_we=0, w_pointer stays 1100, overflow=1 and stays 1. clr_ovf=1 with wr_req=0 -> overflow=0 the next cycle. clr_ovf=1 with wr_req=1, f_flag=1 -> overflow stays 1.
- Almost-full: from empty, write 5 -> almost_full=0. 6th write -> almost_full=1 the next cycle. Advance r_pointer to 0001 (one read) -> almost_full=0 one cycle later.
- Wrap: r_pointer tracks to 1100, then 8 more writes -> w_pointer returns to 0000 through 1101,1111,1110,1010,1011,1001,1000; w_addr wraps 7->0; w_count=8 at the end.
- Idle hold: wr_req=0 for 10 cycles with random r_pointer changes -> w_pointer and w_addr unchanged, mem_we=0, w_count tracks r_pointer.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer controller: gates writes against the full flag, keeps a binary
// write counter with a registered Gray copy, and reports fill level, almost-full and overflow.
module fifo_wr_ctrl #(
  parameter int SIZE     = 4,
  parameter int AF_LEVEL = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_req,
  input  logic            f_flag,
  input  logic [SIZE-1:0] r_pointer,
  input  logic            clr_ovf,
  output logic [SIZE-1:0] w_pointer,
  output logic [SIZE-2:0] w_addr,
  output logic            mem_we,
  output logic [SIZE-1:0] w_count,
  output logic            almost_full,
  output logic            overflow
);

  localparam logic [SIZE-1:0] ONE_C      = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [SIZE-1:0] AF_LEVEL_C = SIZE'(AF_LEVEL);

  function automatic logic [SIZE-1:0] bin2gray(input logic [SIZE-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [SIZE-1:0] gray2bin(input logic [SIZE-1:0] g);
    logic [SIZE-1:0] b;
    b = g;
    for (int i = SIZE - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [SIZE-1:0] w_bin_r;
  logic [SIZE-1:0] w_ptr_r;
  logic            ovf_r;
  logic            af_r;

  logic            accept_s;
  logic [SIZE-1:0] w_bin_next_s;
  logic [SIZE-1:0] r_bin_s;
  logic [SIZE-1:0] w_count_s;
  logic [SIZE-1:0] w_count_next_s;
  logic            ovf_next_s;

  // Accept gating, next write counter, fill level and overflow next-state.
  always_comb begin
    accept_s       = 1'b0;
    w_bin_next_s   = w_bin_r;
    ovf_next_s     = ovf_r;
    r_bin_s        = gray2bin(r_pointer);

    // An in-flight write is dropped while reset is held.
    if (rst_n) begin
      accept_s = wr_req & ~f_flag;
    end else begin
      accept_s = 1'b0;
    end

    if (accept_s) begin
      w_bin_next_s = w_bin_r + ONE_C;
    end else begin
      w_bin_next_s = w_bin_r;
    end

    // A refused write wins over a same-cycle clear.
    if (wr_req && f_flag) begin
      ovf_next_s = 1'b1;
    end else if (clr_ovf) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = ovf_r;
    end

    w_count_s      = w_bin_r - r_bin_s;
    w_count_next_s = w_bin_next_s - r_bin_s;
  end

  // Write counter, Gray pointer, overflow and almost-full registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_bin_r <= {SIZE{1'b0}};
      w_ptr_r <= {SIZE{1'b0}};
      ovf_r   <= 1'b0;
      af_r    <= 1'b0;
    end else begin
      w_bin_r <= w_bin_next_s;
      w_ptr_r <= bin2gray(w_bin_next_s);
      ovf_r   <= ovf_next_s;
      af_r    <= (w_count_next_s >= AF_LEVEL_C);
    end
  end

  assign w_pointer   = w_ptr_r;
  assign w_addr      = w_bin_r[SIZE-2:0];
  assign mem_we      = accept_s;
  assign w_count     = w_count_s;
  assign almost_full = af_r;
  assign overflow    = ovf_r;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl (SIZE=4, AF_LEVEL=6) with hand-computed expectations.
module tb_fifo_wr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_req;
  logic       f_flag;
  logic [3:0] r_pointer;
  logic       clr_ovf;
  logic [3:0] w_pointer;
  logic [2:0] w_addr;
  logic       mem_we;
  logic [3:0] w_count;
  logic       almost_full;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-written Gray codes of binary 0..15.
  logic [3:0] gray_tbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};
  // almost_full after the k-th write from empty (k = 1..8).
  logic       af_tbl [8]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  fifo_wr_ctrl #(.SIZE(4), .AF_LEVEL(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_req     (wr_req),
    .f_flag     (f_flag),
    .r_pointer  (r_pointer),
    .clr_ovf    (clr_ovf),
    .w_pointer  (w_pointer),
    .w_addr     (w_addr),
    .mem_we     (mem_we),
    .w_count    (w_count),
    .almost_full(almost_full),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a pending write request.
    rst_n     = 1'b0;
    wr_req    = 1'b1;
    f_flag    = 1'b0;
    r_pointer = 4'b0000;
    clr_ovf   = 1'b0;
    #12;
    check_val("rst_wptr", int'(w_pointer), 0);
    check_val("rst_waddr", int'(w_addr), 0);
    check_val("rst_we", int'(mem_we), 0);
    check_val("rst_count", int'(w_count), 0);
    check_val("rst_ovf", int'(overflow), 0);
    check_val("rst_af", int'(almost_full), 0);
    rst_n = 1'b1;

    // Gray walk: 8 writes from empty.
    for (int i = 0; i < 8; i++) begin
      wr_req = 1'b1;
      #1;
      check_val("walk_we", int'(mem_we), 1);
      check_val("walk_addr", int'(w_addr), i);
      check_val("walk_cnt", int'(w_count), i);
      tick();
      check_val("walk_wptr", int'(w_pointer), int'(gray_tbl[i+1]));
      check_val("walk_af", int'(almost_full), int'(af_tbl[i]));
    end
    wr_req = 1'b0;
    #1;
    check_val("walk_full_cnt", int'(w_count), 8);

    // Full refusal.
    f_flag = 1'b1;
    wr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("full_we", int'(mem_we), 0);
      tick();
      check_val("full_wptr", int'(w_pointer), 12);
      check_val("full_ovf", int'(overflow), 1);
      check_val("full_cnt", int'(w_count), 8);
    end
    wr_req  = 1'b0;
    clr_ovf = 1'b1;
    tick();
    check_val("clr_ovf", int'(overflow), 0);
    wr_req = 1'b1;
    tick();
    check_val("set_beats_clr", int'(overflow), 1);
    check_val("set_beats_clr_wptr", int'(w_pointer), 12);
    wr_req = 1'b0;
    tick();
    check_val("clr_ovf2", int'(overflow), 0);
    clr_ovf = 1'b0;
    f_flag  = 1'b0;

    // Read side catches up: empty again.
    r_pointer = 4'b1100;
    #1;
    check_val("empty_cnt", int'(w_count), 0);
    tick();
    check_val("empty_af", int'(almost_full), 0);

    // Wrap: 8 writes from w_bin=8 back to 0.
    for (int i = 0; i < 8; i++) begin
      wr_req = 1'b1;
      #1;
      check_val("wrap_we", int'(mem_we), 1);
      check_val("wrap_addr", int'(w_addr), i);
      tick();
      check_val("wrap_wptr", int'(w_pointer), int'(gray_tbl[(i + 9) % 16]));
      check_val("wrap_af", int'(almost_full), int'(af_tbl[i]));
    end
    wr_req = 1'b0;
    #1;
    check_val("wrap_addr_end", int'(w_addr), 0);
    check_val("wrap_cnt_end", int'(w_count), 8);

    // Reads bring level to 5: almost_full drops one cycle later.
    r_pointer = 4'b1110;
    #1;
    check_val("rd_cnt", int'(w_count), 5);
    check_val("rd_af_before", int'(almost_full), 1);
    tick();
    check_val("rd_af_after", int'(almost_full), 0);

    // Idle hold with changing read pointer (binary 8..15, so level 8..1).
    for (int i = 0; i < 10; i++) begin
      int b;
      b = int'($urandom_range(8, 15));
      r_pointer = gray_tbl[b];
      #1;
      check_val("idle_we", int'(mem_we), 0);
      check_val("idle_cnt", int'(w_count), 16 - b);
      tick();
      check_val("idle_wptr", int'(w_pointer), 0);
      check_val("idle_addr", int'(w_addr), 0);
    end

    // Mid-stream asynchronous reset.
    r_pointer = 4'b0000;
    wr_req    = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_val("pre_rst_wptr", int'(w_pointer), 2);
    check_val("pre_rst_cnt", int'(w_count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_wptr", int'(w_pointer), 0);
    check_val("mid_rst_addr", int'(w_addr), 0);
    check_val("mid_rst_we", int'(mem_we), 0);
    check_val("mid_rst_cnt", int'(w_count), 0);
    check_val("mid_rst_ovf", int'(overflow), 0);
    tick();
    check_val("hold_rst_wptr", int'(w_pointer), 0);
    check_val("hold_rst_we", int'(mem_we), 0);
    wr_req = 1'b0;
    rst_n  = 1'b1;
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
